// File: rtl/dcache_lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states and defaults.
package lsu_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W     = 32;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } lsu_size_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_WRITE  = 2'b10,
      ST_RESP   = 2'b11
   } lsu_state_e;

endpackage

// File: rtl/dcache_lsu_if.sv
// Request/response channel from execute plus the data-cache port, bundled for the LSU.
interface dcache_lsu_if #(
   parameter int ADDR_W = 12
);

   // Handshake: a request transfers on a rising edge where req_valid_i && req_ready_o;
   // the requester holds all req_* stable while valid is high and ready is low, and
   // ready depends only on LSU state, never on valid. rsp_valid_o is a one-cycle
   // pulse with no back-pressure.
   logic              req_valid_i;
   logic              req_ready_o;
   logic              req_we_i;
   logic [1:0]        req_size_i;
   logic              req_unsigned_i;
   logic [ADDR_W-1:0] req_addr_i;
   logic [31:0]       req_wdata_i;

   logic              rsp_valid_o;
   logic [31:0]       rsp_data_o;
   logic              rsp_err_o;

   logic              dc_writeen_o;
   logic              dc_readen_o;
   logic [ADDR_W-3:0] dc_addr_o;
   logic [31:0]       dc_dato_o;
   logic [31:0]       dc_dato_i;

   modport slave (
      input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
      input  dc_dato_i,
      output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
      output dc_writeen_o, dc_readen_o, dc_addr_o, dc_dato_o
   );

   modport master (
      output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
      output dc_dato_i,
      input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
      input  dc_writeen_o, dc_readen_o, dc_addr_o, dc_dato_o
   );

endinterface

// File: rtl/dcache_lsu_lane.sv
// Little-endian lane logic: load extraction with extension, sub-word store merge,
// and the alignment/legality check for an incoming request.
module dcache_lsu_lane
   import lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [15:0] wdata_i,
   input  logic [1:0]  offset_i,
   input  lsu_size_e   size_i,
   input  logic        unsigned_i,
   input  logic [1:0]  chk_offset_i,
   input  lsu_size_e   chk_size_i,
   output logic [31:0] ext_o,
   output logic [31:0] merged_o,
   output logic        misalign_o
);

   logic [4:0]  bit_off;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      bit_off  = {offset_i, 3'b000};
      byte_sel = word_i[bit_off +: 8];
      half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
   end

   always_comb begin
      ext_o = word_i;
      case (size_i)
         SZ_BYTE: ext_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
         SZ_HALF: ext_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
         default: ext_o = word_i;
      endcase
   end

   always_comb begin
      merged_o = word_i;
      case (size_i)
         SZ_BYTE: merged_o[bit_off +: 8] = wdata_i[7:0];
         SZ_HALF: begin
            if (offset_i[1]) merged_o[31:16] = wdata_i;
            else             merged_o[15:0]  = wdata_i;
         end
         default: merged_o = word_i;
      endcase
   end

   // Illegal size is folded into the same error flag as misalignment.
   always_comb begin
      misalign_o = 1'b1;
      case (chk_size_i)
         SZ_BYTE: misalign_o = 1'b0;
         SZ_HALF: misalign_o = chk_offset_i[0];
         SZ_WORD: misalign_o = |chk_offset_i;
         default: misalign_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/dcache_lsu.sv
// Load/store unit in front of the data cache: request latch, four-state access FSM,
// read-modify-write for sub-word stores and a registered one-cycle response.
module dcache_lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic         clk_i,
   input  logic         rst_i,
   dcache_lsu_if.slave  bus,
   output lsu_state_e   state_o
);

   lsu_state_e        state_q, state_d;
   logic              we_q, we_d;
   lsu_size_e         size_q, size_d;
   logic              uns_q, uns_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       merged_q, merged_d;
   logic [31:0]       rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;

   logic              accept;
   logic              sub_store;
   logic [31:0]       lane_ext;
   logic [31:0]       lane_merged;
   logic              req_misalign;

   dcache_lsu_lane u_lane (
      .word_i       (bus.dc_dato_i),
      .wdata_i      (wdata_q[15:0]),
      .offset_i     (addr_q[1:0]),
      .size_i       (size_q),
      .unsigned_i   (uns_q),
      .chk_offset_i (bus.req_addr_i[1:0]),
      .chk_size_i   (lsu_size_e'(bus.req_size_i)),
      .ext_o        (lane_ext),
      .merged_o     (lane_merged),
      .misalign_o   (req_misalign)
   );

   assign accept    = (state_q == ST_IDLE) && bus.req_valid_i;
   assign sub_store = we_q && (size_q != SZ_WORD);
   assign state_o   = state_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (accept) state_d = req_misalign ? ST_RESP : ST_ACCESS;
         ST_ACCESS: state_d = sub_store ? ST_WRITE : ST_RESP;
         ST_WRITE:  state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Strobes and address decode from state and the latched request only.
   always_comb begin
      bus.req_ready_o  = (state_q == ST_IDLE);
      bus.rsp_valid_o  = (state_q == ST_RESP);
      bus.rsp_data_o   = (state_q == ST_RESP) ? rsp_data_q : 32'h0;
      bus.rsp_err_o    = (state_q == ST_RESP) ? rsp_err_q : 1'b0;
      bus.dc_readen_o  = (state_q == ST_ACCESS) && (!we_q || sub_store);
      bus.dc_writeen_o = ((state_q == ST_ACCESS) && we_q && !sub_store) || (state_q == ST_WRITE);
      bus.dc_addr_o    = '0;
      bus.dc_dato_o    = 32'h0;
      if ((state_q == ST_ACCESS) || (state_q == ST_WRITE)) bus.dc_addr_o = addr_q[ADDR_W-1:2];
      if ((state_q == ST_ACCESS) && we_q && !sub_store)    bus.dc_dato_o = wdata_q;
      if (state_q == ST_WRITE)                             bus.dc_dato_o = merged_q;
   end

   always_comb begin
      we_d       = we_q;
      size_d     = size_q;
      uns_d      = uns_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      merged_d   = merged_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               we_d       = bus.req_we_i;
               size_d     = lsu_size_e'(bus.req_size_i);
               uns_d      = bus.req_unsigned_i;
               addr_d     = bus.req_addr_i;
               wdata_d    = bus.req_wdata_i;
               rsp_data_d = 32'h0;
               rsp_err_d  = req_misalign;
            end
         end
         ST_ACCESS: begin
            if (!we_q)          rsp_data_d = lane_ext;
            else if (sub_store) merged_d   = lane_merged;
         end
         ST_RESP: begin
            rsp_data_d = 32'h0;
            rsp_err_d  = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         we_q       <= 1'b0;
         size_q     <= SZ_BYTE;
         uns_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 32'h0;
         merged_q   <= 32'h0;
         rsp_data_q <= 32'h0;
         rsp_err_q  <= 1'b0;
      end else begin
         we_q       <= we_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         merged_q   <= merged_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_dcache_lsu.sv
// Directed bench for dcache_lsu with a behavioural cache memory and a response scoreboard.
module tb_dcache_lsu;
   import lsu_pkg::*;

   logic       clk_i = 1'b0;
   logic       rst_i;
   lsu_state_e state_o;

   dcache_lsu_if #(.ADDR_W(12)) bus ();

   dcache_lsu #(.ADDR_W(12)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .bus     (bus),
      .state_o (state_o)
   );

   always #5 clk_i = ~clk_i;

   // Behavioural data cache: combinational read, write on the rising edge.
   logic [31:0] mem [0:1023];
   logic        pre_en;
   logic [9:0]  pre_addr;
   logic [31:0] pre_data;

   assign bus.dc_dato_i = mem[bus.dc_addr_o];

   always @(posedge clk_i) begin
      if (bus.dc_writeen_o) mem[bus.dc_addr_o] <= bus.dc_dato_o;
      else if (pre_en)      mem[pre_addr]      <= pre_data;
   end

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   logic [32:0] exp_q [$];
   int          acc_q [$];
   int          lat_q [$];

   int          checks = 0;
   int          errors = 0;
   int          we_cnt = 0;
   int          re_cnt = 0;
   logic [9:0]  last_waddr;
   logic [31:0] last_wdata;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      assert (act === expv) else begin
         errors++;
         $error("FAIL %s: got %h, expected %h", tag, act, expv);
      end
   endtask

   task automatic monitor();
      logic [32:0] e;
      int          a;
      int          l;
      forever begin
         @(negedge clk_i);
         if (!rst_i) begin
            checks++;
            assert (!(bus.dc_writeen_o && bus.dc_readen_o)) else begin
               errors++;
               $error("FAIL strobe_excl: we=%b re=%b both high", bus.dc_writeen_o, bus.dc_readen_o);
            end
            if (bus.dc_writeen_o) begin
               we_cnt++;
               last_waddr = bus.dc_addr_o;
               last_wdata = bus.dc_dato_o;
            end
            if (bus.dc_readen_o) re_cnt++;
            if (bus.rsp_valid_o) begin
               checks++;
               assert (exp_q.size() > 0) else begin
                  errors++;
                  $error("FAIL rsp_unexpected: got data %h err %b, expected no response",
                         bus.rsp_data_o, bus.rsp_err_o);
               end
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  a = acc_q.pop_front();
                  l = lat_q.pop_front();
                  chk("rsp_data", bus.rsp_data_o, e[31:0]);
                  chk("rsp_err", {31'h0, bus.rsp_err_o}, {31'h0, e[32]});
                  chk("rsp_latency", cyc - a, l);
               end
            end else begin
               checks++;
               assert ((bus.rsp_data_o === 32'h0) && (bus.rsp_err_o === 1'b0)) else begin
                  errors++;
                  $error("FAIL rsp_idle: got data %h err %b, expected 0 0", bus.rsp_data_o, bus.rsp_err_o);
               end
            end
         end
      end
   endtask

   task automatic preload(input logic [9:0] wa, input logic [31:0] wd);
      pre_en   = 1'b1;
      pre_addr = wa;
      pre_data = wd;
      @(negedge clk_i);
      pre_en   = 1'b0;
   endtask

   // Called at a falling edge; returns at the falling edge after the accept edge.
   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [11:0] addr, input logic [31:0] wdata,
                        input logic [32:0] expv, input int lat, input bit track);
      int n;
      n = 0;
      bus.req_valid_i    = 1'b1;
      bus.req_we_i       = we;
      bus.req_size_i     = size;
      bus.req_unsigned_i = uns;
      bus.req_addr_i     = addr;
      bus.req_wdata_i    = wdata;
      while (!bus.req_ready_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      chk("accept_ready", {31'h0, bus.req_ready_o}, 32'h1);
      if (track) begin
         exp_q.push_back(expv);
         acc_q.push_back(cyc);
         lat_q.push_back(lat);
      end
      @(negedge clk_i);
      bus.req_valid_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      @(negedge clk_i);
      chk("drain_pending", exp_q.size(), 0);
   endtask

   initial begin
      int w0;
      int r0;
      int n;
      int acc1;
      logic [11:0] ra;
      logic [31:0] rd;

      rst_i              = 1'b1;
      pre_en             = 1'b0;
      pre_addr           = '0;
      pre_data           = '0;
      bus.req_valid_i    = 1'b0;
      bus.req_we_i       = 1'b0;
      bus.req_size_i     = 2'b00;
      bus.req_unsigned_i = 1'b0;
      bus.req_addr_i     = '0;
      bus.req_wdata_i    = '0;
      fork
         monitor();
      join_none

      repeat (3) @(negedge clk_i);
      chk("rst_rsp_valid", {31'h0, bus.rsp_valid_o}, 32'h0);
      chk("rst_rsp_data", bus.rsp_data_o, 32'h0);
      chk("rst_rsp_err", {31'h0, bus.rsp_err_o}, 32'h0);
      chk("rst_dc_we", {31'h0, bus.dc_writeen_o}, 32'h0);
      chk("rst_dc_re", {31'h0, bus.dc_readen_o}, 32'h0);
      chk("rst_dc_addr", {22'h0, bus.dc_addr_o}, 32'h0);
      chk("rst_dc_dato", bus.dc_dato_o, 32'h0);
      chk("rst_state", {30'h0, state_o}, {30'h0, ST_IDLE});
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("rst_ready", {31'h0, bus.req_ready_o}, 32'h1);

      // Word store then word load of the same location.
      w0 = we_cnt;
      issue(1'b1, SZ_WORD, 1'b0, 12'h010, 32'h12345678, {1'b0, 32'h0}, 2, 1'b1);
      drain();
      chk("wst_we_cnt", we_cnt - w0, 1);
      chk("wst_addr", {22'h0, last_waddr}, 32'h004);
      chk("wst_data", last_wdata, 32'h12345678);
      chk("wst_mem", mem[4], 32'h12345678);
      issue(1'b0, SZ_WORD, 1'b0, 12'h010, 32'h0, {1'b0, 32'h12345678}, 2, 1'b1);
      drain();

      // Lane extraction with sign/zero extension.
      preload(10'h004, 32'h8899AABB);
      r0 = re_cnt;
      issue(1'b0, SZ_BYTE, 1'b0, 12'h013, 32'h0, {1'b0, 32'hFFFFFF88}, 2, 1'b1);
      issue(1'b0, SZ_BYTE, 1'b1, 12'h013, 32'h0, {1'b0, 32'h00000088}, 2, 1'b1);
      issue(1'b0, SZ_HALF, 1'b0, 12'h012, 32'h0, {1'b0, 32'hFFFF8899}, 2, 1'b1);
      issue(1'b0, SZ_HALF, 1'b1, 12'h010, 32'h0, {1'b0, 32'h0000AABB}, 2, 1'b1);
      issue(1'b0, SZ_BYTE, 1'b0, 12'h011, 32'h0, {1'b0, 32'hFFFFFFAA}, 2, 1'b1);
      issue(1'b0, SZ_BYTE, 1'b0, 12'h012, 32'h0, {1'b0, 32'hFFFFFF99}, 2, 1'b1);
      drain();
      chk("ld_re_cnt", re_cnt - r0, 6);

      // Sub-word stores use read-modify-write.
      preload(10'h004, 32'h12345678);
      r0 = re_cnt;
      w0 = we_cnt;
      issue(1'b1, SZ_BYTE, 1'b0, 12'h011, 32'hFFFFFF5A, {1'b0, 32'h0}, 3, 1'b1);
      drain();
      chk("bst_re_cnt", re_cnt - r0, 1);
      chk("bst_we_cnt", we_cnt - w0, 1);
      chk("bst_addr", {22'h0, last_waddr}, 32'h004);
      chk("bst_data", last_wdata, 32'h12345A78);
      chk("bst_mem", mem[4], 32'h12345A78);
      issue(1'b1, SZ_HALF, 1'b0, 12'h012, 32'h0000BEEF, {1'b0, 32'h0}, 3, 1'b1);
      drain();
      chk("hst_mem", mem[4], 32'hBEEF5A78);
      issue(1'b0, SZ_WORD, 1'b0, 12'h010, 32'h0, {1'b0, 32'hBEEF5A78}, 2, 1'b1);
      drain();

      // Misaligned and illegal requests never touch the cache.
      r0 = re_cnt;
      w0 = we_cnt;
      issue(1'b0, SZ_HALF, 1'b0, 12'h013, 32'h0, {1'b1, 32'h0}, 1, 1'b1);
      issue(1'b0, SZ_ILL, 1'b0, 12'h010, 32'h0, {1'b1, 32'h0}, 1, 1'b1);
      issue(1'b1, SZ_WORD, 1'b0, 12'h012, 32'hDEADBEEF, {1'b1, 32'h0}, 1, 1'b1);
      issue(1'b1, SZ_HALF, 1'b0, 12'h011, 32'h00001111, {1'b1, 32'h0}, 1, 1'b1);
      drain();
      chk("err_re_cnt", re_cnt - r0, 0);
      chk("err_we_cnt", we_cnt - w0, 0);
      chk("err_mem", mem[4], 32'hBEEF5A78);

      // Reset during the read phase of a byte store aborts it cleanly.
      preload(10'h004, 32'h12345678);
      w0 = we_cnt;
      issue(1'b1, SZ_BYTE, 1'b0, 12'h011, 32'h0000005A, {1'b0, 32'h0}, 0, 1'b0);
      chk("abort_in_access", {30'h0, state_o}, {30'h0, ST_ACCESS});
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      chk("abort_ready", {31'h0, bus.req_ready_o}, 32'h1);
      repeat (5) @(negedge clk_i);
      chk("abort_we_cnt", we_cnt - w0, 0);
      chk("abort_mem", mem[4], 32'h12345678);

      // Two loads back to back with valid held high.
      preload(10'h005, 32'hCAFEF00D);
      bus.req_valid_i    = 1'b1;
      bus.req_we_i       = 1'b0;
      bus.req_size_i     = SZ_WORD;
      bus.req_unsigned_i = 1'b0;
      bus.req_addr_i     = 12'h010;
      chk("b2b_ready0", {31'h0, bus.req_ready_o}, 32'h1);
      acc1 = cyc;
      exp_q.push_back({1'b0, 32'h12345678});
      acc_q.push_back(cyc);
      lat_q.push_back(2);
      @(negedge clk_i);
      bus.req_addr_i = 12'h014;
      n = 0;
      while (!bus.req_ready_o && n < 10) begin
         @(negedge clk_i);
         n++;
      end
      chk("b2b_stall_cycles", n, 2);
      chk("b2b_accept_gap", cyc - acc1, 3);
      exp_q.push_back({1'b0, 32'hCAFEF00D});
      acc_q.push_back(cyc);
      lat_q.push_back(2);
      @(negedge clk_i);
      bus.req_valid_i = 1'b0;
      drain();

      // Random word store/load round trips.
      for (int i = 0; i < 6; i++) begin
         ra = {$urandom_range(0, 1023), 2'b00};
         rd = $urandom;
         issue(1'b1, SZ_WORD, 1'b0, ra, rd, {1'b0, 32'h0}, 2, 1'b1);
         issue(1'b0, SZ_WORD, 1'b0, ra, 32'h0, {1'b0, rd}, 2, 1'b1);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
